// File: rtl/encryption_core256.sv
// Iterative AES-256 encryptor: one round per clock, round keys expanded on the fly
// two at a time from the 256-bit cipher key, valid/ready on input and output.
module encryption_core256 (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [255:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [1:0]   dbg_fsm
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, so the two never overlap.
    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} fsm_t;

    fsm_t         fsm, fsm_next;
    logic [127:0] state;
    logic [255:0] keyreg;
    logic [7:0]   rcon;
    logic [3:0]   rnd;
    logic [127:0] sr, mc, rk, round_out;
    logic [255:0] kx;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from the field inverse x^254 (0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s, inv;
        s   = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s   = gmul(s, s);
            inv = gmul(inv, s);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte 4*c+r sits at bits [127-8*(4*c+r) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Produces the next round-key pair (RK2k+2, RK2k+3) from (RK2k, RK2k+1).
    function automatic logic [255:0] key_expansion_256(input logic [255:0] k,
                                                       input logic [31:0]  rc);
        logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
        logic [31:0] w8, w9, w10, w11, w12, w13, w14, w15;
        {w0, w1, w2, w3, w4, w5, w6, w7} = k;
        w8  = w0 ^ sub_word({w7[23:0], w7[31:24]}) ^ rc;
        w9  = w1 ^ w8;
        w10 = w2 ^ w9;
        w11 = w3 ^ w10;
        w12 = w4 ^ sub_word(w11);
        w13 = w5 ^ w12;
        w14 = w6 ^ w13;
        w15 = w7 ^ w14;
        return {w8, w9, w10, w11, w12, w13, w14, w15};
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                   input logic [127:0] k);
        return s ^ k;
    endfunction

    assign kx = key_expansion_256(keyreg, {rcon, 24'h0});

    // Odd rounds take the second half of the held pair; even rounds take the freshly expanded key.
    always_comb begin
        sr        = shift_rows(sub_bytes(state));
        mc        = mix_columns(sr);
        rk        = rnd[0] ? keyreg[127:0] : kx[255:128];
        round_out = add_round_key((rnd == 4'd14) ? sr : mc, rk);
    end

    always_comb begin
        fsm_next = fsm;
        case (fsm)
            IDLE:    if (in_valid) fsm_next = ROUND;
            ROUND: begin
                if (rnd == 4'd0 || rnd == 4'd15) fsm_next = IDLE;
                else if (rnd == 4'd14)           fsm_next = DONE;
            end
            DONE:    if (out_ready) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm    <= IDLE;
            state  <= '0;
            keyreg <= '0;
            rcon   <= 8'h01;
            rnd    <= 4'd0;
        end else begin
            fsm <= fsm_next;
            if (fsm == IDLE && in_valid) begin
                state  <= add_round_key(in_data, in_key[255:128]);
                keyreg <= in_key;
                rcon   <= 8'h01;
                rnd    <= 4'd1;
            end else if (fsm == ROUND && rnd != 4'd0 && rnd != 4'd15) begin
                state <= round_out;
                if (!rnd[0]) begin
                    keyreg <= kx;
                    rcon   <= {rcon[6:0], 1'b0};
                end
                if (rnd != 4'd14) rnd <= rnd + 4'd1;
            end
        end
    end

    assign in_ready  = (fsm == IDLE) && !rst;
    assign out_valid = (fsm == DONE);
    assign out_data  = state;
    assign dbg_fsm   = fsm;
endmodule

// File: tb/tb_encryption_core256.sv
// Bench for encryption_core256: known-answer vectors, backpressure, input isolation,
// mid-round reset and a random loopback through an independent AES-256 inverse cipher.
module tb_encryption_core256;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [255:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [1:0]   dbg_fsm;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, n_acc = 0, n_out = 0, n_drop = 0, acc_cyc = 0;
    logic [127:0] exp_q[$];
    logic [255:0] key_q[$];
    logic [128:0] ct_q[$];
    logic [128:0] cur_ct = '0;
    logic [7:0]   sb[256];
    logic [7:0]   isb[256];

    encryption_core256 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .dbg_fsm(dbg_fsm)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: inverse cipher with a generator-built S-box table.
    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = isb[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gm(a0, 14) ^ gm(a1, 11) ^ gm(a2, 13) ^ gm(a3, 9);
            o[119-32*c -: 8] = gm(a0, 9)  ^ gm(a1, 14) ^ gm(a2, 11) ^ gm(a3, 13);
            o[111-32*c -: 8] = gm(a0, 13) ^ gm(a1, 9)  ^ gm(a2, 14) ^ gm(a3, 11);
            o[103-32*c -: 8] = gm(a0, 11) ^ gm(a1, 13) ^ gm(a2, 9)  ^ gm(a3, 14);
        end
        return o;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] ct, input logic [255:0] key);
        logic [31:0]  w[60];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] s;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        s = ct ^ {w[56], w[57], w[58], w[59]};
        for (int r = 13; r >= 1; r--) begin
            s = inv_sub_shift(s) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            s = inv_mix(s);
        end
        return inv_sub_shift(s) ^ {w[0], w[1], w[2], w[3]};
    endfunction

    // Scoreboard and driver tasks.
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input logic [127:0] od);
        logic [128:0] cc;
        logic [255:0] k;
        logic [127:0] pt;
        n_out++;
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            cc = ct_q.pop_front();
            k  = key_q.pop_front();
            pt = exp_q.pop_front();
            check("loopback_decrypt", decrypt(od, k), pt);
            if (cc[128]) check("known_ciphertext", od, cc[127:0]);
        end
    endtask

    // One clock: records any accept / output handshake that happens on this edge.
    task automatic step();
        logic acc, hs;
        logic [127:0] od, d;
        logic [255:0] k;
        logic [128:0] cc;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        od = out_data; d = in_data; k = in_key; cc = cur_ct;
        @(posedge clk); #1;
        if (acc) begin
            exp_q.push_back(d); key_q.push_back(k); ct_q.push_back(cc);
            n_acc++;
            acc_cyc = cyc;
        end
        if (hs) check_out(od);
    endtask

    task automatic run_known(input logic [127:0] pt, input logic [255:0] key, input logic [127:0] ct);
        int k, a;
        cur_ct = {1'b1, ct}; in_data = pt; in_key = key; in_valid = 1; out_ready = 1;
        check("ready_before_accept", in_ready, 1);
        step();
        in_valid = 0;
        a = cyc;
        k = 0;
        while (!out_valid && k < 40) begin step(); k++; end
        check("latency_out_valid", cyc - a, 14);
        check("out_data_direct", out_data, ct);
        step();
        check("out_valid_drop", out_valid, 0);
        k = 0;
        while (!in_ready && k < 40) begin step(); k++; end
        check("next_accept_edge", cyc + 1 - a, 16);
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int k, a, base_acc, base_out, outs_before;
        logic [127:0] held;
        logic ov_seen;
        build_sbox();

        // Reset state.
        repeat (3) begin @(posedge clk); #1; end
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        rst = 0;
        #0;
        check("ready_after_reset", in_ready, 1);

        // Known-answer vectors.
        run_known(C3_PT, C3_KEY, C3_CT);
        run_known('0, '0, Z_CT);

        // Backpressure: 20 stalled cycles with ignored in_valid pulses.
        cur_ct = {1'b1, C3_CT}; in_data = C3_PT; in_key = C3_KEY; in_valid = 1; out_ready = 0;
        step();
        in_valid = 0;
        k = 0;
        while (!out_valid && k < 40) begin step(); k++; end
        check("bp_out_valid_rise", out_valid, 1);
        held = out_data;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0]; in_data = r128(); in_key = {r128(), r128()}; cur_ct = '0;
            step();
            check("bp_valid_held", out_valid, 1);
            check("bp_data_held", out_data, held);
            check("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        outs_before = n_out;
        step();
        check("bp_one_handshake", n_out - outs_before, 1);
        check("bp_valid_drop", out_valid, 0);
        check("bp_idle", in_ready, 1);
        step();
        check("bp_no_second", n_out - outs_before, 1);
        check("bp_sb_empty", exp_q.size(), 0);

        // Input isolation: in_valid held high with random data during the rounds.
        base_acc = n_acc;
        cur_ct = {1'b1, C3_CT}; in_data = C3_PT; in_key = C3_KEY; in_valid = 1; out_ready = 1;
        step();
        a = cyc;
        k = 0;
        while (n_acc < base_acc + 2 && k < 60) begin
            in_data = r128(); in_key = {r128(), r128()}; cur_ct = '0;
            step();
            k++;
        end
        check("iso_two_accepts", n_acc - base_acc, 2);
        check("iso_second_accept_edge", acc_cyc - a, 16);
        in_valid = 0;
        k = 0;
        while (n_out < n_acc - n_drop && k < 60) begin step(); k++; end
        check("iso_sb_empty", exp_q.size(), 0);

        // Reset during round 7 discards the block.
        cur_ct = {1'b1, C3_CT}; in_data = C3_PT; in_key = C3_KEY; in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        repeat (6) step();
        rst = 1;
        step();
        rst = 0;
        #0;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front()); void'(key_q.pop_front()); void'(ct_q.pop_front());
            n_drop++;
        end
        check("rst_ready_next", in_ready, 1);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            ov_seen = ov_seen | out_valid;
            step();
        end
        check("rst_no_out_valid", ov_seen, 0);
        run_known(C3_PT, C3_KEY, C3_CT);

        // Random loopback with output stalls.
        base_acc = n_acc; base_out = n_out;
        in_valid = 1;
        k = 0;
        while (n_acc < base_acc + 200 && k < 8000) begin
            in_data = r128(); in_key = {r128(), r128()}; cur_ct = '0;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            k++;
        end
        in_valid = 0; out_ready = 1;
        k = 0;
        while (n_out - base_out < n_acc - base_acc && k < 100) begin step(); k++; end
        check("lb_accepts", n_acc - base_acc, 200);
        check("lb_outputs", n_out - base_out, 200);
        check("lb_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/encryption_core256.md
# encryption_core256

Iterative AES-256 encryption engine: one round per clock, round keys expanded on the fly from the 256-bit cipher key, valid/ready handshakes on both sides. It is the transmit-side counterpart of the team's combinational AES-256 decryption layer: ciphertext from this block, decrypted with the same key, must reproduce the plaintext. It reuses the team's existing `key_expansion_256`, `add_round_key` and forward SubBytes/ShiftRows/MixColumns primitives, and trades area for a 14-round iterative datapath.

## Interface
- No parameters. Key size is fixed at 256 bits and round count at 14.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  plaintext/key offered.
- `in_ready`  out  1  block can accept; `in_ready = (fsm==IDLE) && !rst`.
- `in_data`  in  128  plaintext block, sampled only on the accept edge.
- `in_key`  in  256  cipher key; `[255:128]` is RK0 and `[127:0]` is RK1. Sampled only on the accept edge.
- `out_valid`  out  1  ciphertext available.
- `out_ready`  in  1  consumer accepts ciphertext.
- `out_data`  out  128  ciphertext; driven directly from the state register.

## Operation
- Registers:
  - `state[127:0]`
  - `keyreg[255:0]`, holding round-key pair (RK2k, RK2k+1)
  - `rcon[7:0]`
  - `rnd[3:0]`
  - `fsm` ∈ {IDLE, ROUND, DONE}
- `kx = key_expansion_256(keyreg, {rcon,24'h0})`, a combinational helper.
- **IDLE:** on `in_valid && in_ready`:
  - `state <= in_data ^ in_key[255:128]` (initial AddRoundKey).
  - `keyreg <= in_key`, `rcon <= 8'h01`, `rnd <= 1`.
  - `fsm <= ROUND`.
- **ROUND**, round `r = rnd`:
  - `t = ShiftRows(SubBytes(state))`.
  - `t = MixColumns(t)`, except when r==14.
  - Round key: r odd uses `keyreg[127:0]`; r even uses `kx[255:128]`.
  - `state <= t ^ roundkey`.
  - On even r, also update `keyreg <= kx` and `rcon <= rcon<<1`.
  - `rnd <= rnd+1`. If r==14, go to DONE instead.
- Resulting key schedule: rcon values 01,02,04,08,10,20,40 are consumed on rounds 2,4,…,14. No rcon beyond 8'h40 is ever used.
- **DONE:**
  - `out_valid=1`.
  - On `out_ready`, go to IDLE.
  - `state`/`out_data` are held unchanged while `out_valid && !out_ready`.
- `in_data`/`in_key` changes after the accept edge have no effect on the block in flight.
- `in_valid` while not IDLE is ignored; `in_ready` is 0, so no accept occurs.
- `rnd` never exceeds 14. Values 0 and 15 are unreachable; if reached, return to IDLE.

## Timing
- **Reset** (synchronous, wins over everything):
  - `fsm=IDLE`, `out_valid=0`, `out_data/state=0`, `keyreg=0`, `rcon=8'h01`, `rnd=0`.
  - `in_ready=0` during the reset cycle and 1 on the first cycle after reset.
- **Reset mid-operation** (ROUND or DONE): the block is discarded, no `out_valid` pulse is produced, and the block is IDLE the next cycle.
- **Latency:** accept at edge E0. Rounds 1–14 execute on edges E1–E14. `out_valid` rises after E14 (14 clocks after accept).
- **Throughput:** with `out_ready` held high, the output handshake completes at E15, IDLE is entered after E15, and the next accept is at E16. That is one block per 16 cycles.
- `in_ready` is low in ROUND and DONE. There is no same-cycle output-handshake-plus-input-accept.
- `out_valid` is deasserted the cycle after the `out_valid && out_ready` edge. It is never asserted for more than one block per accept.
- Critical path: SubBytes → ShiftRows → MixColumns → XOR in parallel with key_expansion_256 → mux. No multicycle paths.

## Test plan
- **FIPS-197 C.3:**
  - Key 000102…1e1f, plaintext 00112233445566778899aabbccddeeff, `out_ready=1`.
  - Required: `out_data=8ea2b7ca516745bfeafc49904b496089`; `out_valid` rises exactly 14 clocks after accept; `in_ready` returns 16 clocks after accept.
- **Zero vector:** key all zeros, plaintext all zeros → `out_data=dc95c078a2408989ad48a21492842087`.
- **Backpressure:**
  - Hold `out_ready=0` for 20 cycles after `out_valid`.
  - Required: `out_valid` and `out_data` stay stable, `in_ready` stays 0, and `in_valid` pulses are ignored.
  - Release `out_ready`: exactly one output handshake, then IDLE.
- **Input isolation:**
  - Accept the C.3 vector, then randomize `in_data`/`in_key` and hold `in_valid=1` every cycle during the rounds.
  - Required: C.3 ciphertext unchanged; the second block is accepted only in IDLE.
- **Reset mid-round:**
  - Assert `rst` for one cycle at round 7.
  - Required: no `out_valid`; `in_ready=1` on the next cycle; a subsequent C.3 run produces the correct ciphertext.
- **Loopback:**
  - 200 random key/plaintext pairs back-to-back with random `out_ready` stalls; feed each `out_data` and key through the decryption layer.
  - Required: recovers the plaintext every time; output count equals accept count.
